// File: rtl/temp_uart_pkg.sv
// Shared types and constants for the temperature-sensor UART transmitter.
// Also imported by the bit timer, so a future receiver can reuse them.
package temp_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam int FRAME_BITS           = 10;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts clock cycles within one UART bit period.
// o_bit_end marks the last cycle of a bit; o_near_end marks the cycle before it.
module uart_bit_timer
   import temp_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   output logic o_bit_end,
   output logic o_near_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] r_clk_cnt;

   assign o_bit_end  = (r_clk_cnt == LAST);
   assign o_near_end = (r_clk_cnt == NEAR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_cnt <= '0;
      end else if (i_clr || o_bit_end) begin
         r_clk_cnt <= '0;
      end else begin
         r_clk_cnt <= r_clk_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/temp_uart_tx.sv
// 8N1 UART transmitter for sensor readings, triggered by start_uart edges.
// A single pending slot queues one frame requested while the line is busy.
module temp_uart_tx
   import temp_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_uart,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   state_t     r_state;
   logic       r_s1;
   logic       r_s2;
   logic       r_s3;
   logic [7:0] r_shift;
   logic [7:0] r_pend_data;
   logic       r_pending;
   logic [2:0] r_bit_idx;
   logic       r_tx;
   logic       r_busy;
   logic       r_done;

   logic       w_edge;
   logic       w_clr;
   logic       w_bit_end;
   logic       w_near_end;
   logic [2:0] w_idx_nxt;

   assign w_edge    = r_s2 & ~r_s3;
   assign w_clr     = (r_state == IDLE);
   assign w_idx_nxt = r_bit_idx + 3'd1;

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clr      (w_clr),
      .o_bit_end  (w_bit_end),
      .o_near_end (w_near_end)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= start_uart;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_pend_data <= '0;
         r_pending   <= 1'b0;
         r_bit_idx   <= '0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= (r_state == STOP) && w_near_end;
         if (w_edge && (r_state != IDLE)) begin
            r_pending   <= 1'b1;
            r_pend_data <= data_in;
         end
         unique case (r_state)
            IDLE: begin
               if (w_edge) begin
                  r_state <= START;
                  r_shift <= data_in;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_state   <= DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_bit_idx == LAST_IDX) begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= w_idx_nxt;
                     r_tx      <= r_shift[w_idx_nxt];
                  end
               end
            end
            STOP: begin
               // An edge on this very cycle is newer than any queued byte.
               if (w_bit_end) begin
                  if (w_edge || r_pending) begin
                     r_state   <= START;
                     r_shift   <= w_edge ? data_in : r_pend_data;
                     r_pending <= 1'b0;
                     r_tx      <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
